cache_req_scheduler: RTL and testbench

- Two-port front end that shares the single cache_and_ram instance between two requesters, port 0 (fetch) and port 1 (load/store).
- Accepts requests with a valid/ready handshake and arbitrates round-robin.
- Issues one transaction at a time to the cache and sequences the fixed read latency.
- Returns one response pulse to the requester that issued the transaction, with the read data or a write acknowledge.

---
 rtl/cache_sched_pkg.sv | 18 +
 rtl/cache_req_scheduler_rr_arb2.sv | 34 +++
 rtl/cache_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_cache_req_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sched_pkg.sv
// Shared types and constants for the two-port cache request scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package cache_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/cache_req_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the two valids and
// the last granted port, with the last-grant register advanced on accept.
module rr_arb2
    import cache_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_accept,
    output logic o_grant
);

    logic r_lastGrant;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        o_grant = P0;
        if (i_valid0 && i_valid1) begin
            o_grant = ~r_lastGrant;
        end else if (i_valid1) begin
            o_grant = P1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= P1;
        end else if (i_accept) begin
            r_lastGrant <= o_grant;
        end
    end

endmodule

// File: rtl/cache_req_scheduler.sv
// Shares one cache between a fetch port and a load/store port: round-robin
// accept, one transaction in flight, fixed-latency wait, one response pulse.
module cache_req_scheduler
    import cache_sched_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_mode,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t            r_state;
    logic [3:0]        r_waitCnt;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_memAddress;
    logic [DATA_W-1:0] r_memData;
    logic              r_memMode;
    logic              r_rsp0Valid;
    logic              r_rsp1Valid;
    logic [DATA_W-1:0] r_rsp0Rdata;
    logic [DATA_W-1:0] r_rsp1Rdata;

    logic              w_grant;
    logic              w_idle;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_reqWe;
    logic [ADDR_W-1:0] w_reqAddr;
    logic [DATA_W-1:0] w_reqWdata;
    logic [DATA_W-1:0] w_capture;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_ready0   = w_idle && (w_grant == P0);
    assign w_ready1   = w_idle && (w_grant == P1);
    assign w_accept   = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
    assign w_reqWe    = (w_grant == P1) ? req1_we    : req0_we;
    assign w_reqAddr  = (w_grant == P1) ? req1_addr  : req0_addr;
    assign w_reqWdata = (w_grant == P1) ? req1_wdata : req0_wdata;
    // A write acknowledges with its own data, a read with the cache output.
    assign w_capture  = (r_we == MODE_WRITE) ? r_memData : mem_out;

    // The mem_* registers double as the latched request; mode drops after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_waitCnt    <= '0;
            r_port       <= P0;
            r_we         <= MODE_READ;
            r_memAddress <= '0;
            r_memData    <= '0;
            r_memMode    <= MODE_READ;
            r_rsp0Valid  <= 1'b0;
            r_rsp1Valid  <= 1'b0;
            r_rsp0Rdata  <= '0;
            r_rsp1Rdata  <= '0;
        end else begin
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port       <= w_grant;
                        r_we         <= w_reqWe;
                        r_memAddress <= w_reqAddr;
                        r_memData    <= w_reqWdata;
                        r_memMode    <= w_reqWe;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_memMode <= MODE_READ;
                    r_waitCnt <= LAT_LAST;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        if (r_port == P1) begin
                            r_rsp1Rdata <= w_capture;
                            r_rsp1Valid <= 1'b1;
                        end else begin
                            r_rsp0Rdata <= w_capture;
                            r_rsp0Valid <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign rsp0_valid  = r_rsp0Valid;
    assign rsp1_valid  = r_rsp1Valid;
    assign rsp0_rdata  = r_rsp0Rdata;
    assign rsp1_rdata  = r_rsp1Rdata;
    assign mem_address = r_memAddress;
    assign mem_data    = r_memData;
    assign mem_mode    = r_memMode;

endmodule

// File: tb/tb_cache_req_scheduler.sv
// Directed bench for cache_req_scheduler: one instance at MEM_LATENCY = 1 and
// one at MEM_LATENCY = 3, each backed by a small behavioural cache model.
module tb_cache_req_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memInit = 1'b1;
    int          cycle = 0;
    int          checkCount = 0;
    int          errorCount = 0;

    // Index order: [dut][port]; dut 0 has latency 1, dut 1 has latency 3.
    logic        reqValid  [2][2];
    logic        reqReady  [2][2];
    logic        reqWe     [2][2];
    logic [31:0] reqAddr   [2][2];
    logic [31:0] reqWdata  [2][2];
    logic        rspValid  [2][2];
    logic [31:0] rspRdata  [2][2];
    logic [31:0] memAddress[2];
    logic [31:0] memData   [2];
    logic        memMode   [2];
    logic [31:0] memOut    [2];

    logic [31:0] memArr    [2][64];
    logic [31:0] pipe      [2][4];

    bit          logB2B = 1'b0;
    int          b2bTime[$];
    logic [31:0] b2bData[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    cache_req_scheduler #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(reqValid[0][0]), .req0_ready(reqReady[0][0]), .req0_we(reqWe[0][0]),
        .req0_addr(reqAddr[0][0]), .req0_wdata(reqWdata[0][0]),
        .rsp0_valid(rspValid[0][0]), .rsp0_rdata(rspRdata[0][0]),
        .req1_valid(reqValid[0][1]), .req1_ready(reqReady[0][1]), .req1_we(reqWe[0][1]),
        .req1_addr(reqAddr[0][1]), .req1_wdata(reqWdata[0][1]),
        .rsp1_valid(rspValid[0][1]), .rsp1_rdata(rspRdata[0][1]),
        .mem_address(memAddress[0]), .mem_data(memData[0]), .mem_mode(memMode[0]),
        .mem_out(memOut[0])
    );

    cache_req_scheduler #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(reqValid[1][0]), .req0_ready(reqReady[1][0]), .req0_we(reqWe[1][0]),
        .req0_addr(reqAddr[1][0]), .req0_wdata(reqWdata[1][0]),
        .rsp0_valid(rspValid[1][0]), .rsp0_rdata(rspRdata[1][0]),
        .req1_valid(reqValid[1][1]), .req1_ready(reqReady[1][1]), .req1_we(reqWe[1][1]),
        .req1_addr(reqAddr[1][1]), .req1_wdata(reqWdata[1][1]),
        .rsp1_valid(rspValid[1][1]), .rsp1_rdata(rspRdata[1][1]),
        .mem_address(memAddress[1]), .mem_data(memData[1]), .mem_mode(memMode[1]),
        .mem_out(memOut[1])
    );

    // Cache model: samples on posedge, result appears after the configured latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (memInit) begin
                for (int i = 0; i < 64; i++) memArr[d][i] <= 32'hA000_0000 | 32'(i);
            end else if (memMode[d]) begin
                memArr[d][memAddress[d][7:2]] <= memData[d];
            end
            for (int k = 3; k > 0; k--) pipe[d][k] <= pipe[d][k-1];
            pipe[d][0] <= memMode[d] ? memData[d] : memArr[d][memAddress[d][7:2]];
        end
    end

    assign memOut[0] = pipe[0][0];
    assign memOut[1] = pipe[1][2];

    always @(negedge clk) begin
        if (logB2B && rspValid[0][1]) begin
            b2bTime.push_back(cycle);
            b2bData.push_back(rspRdata[0][1]);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One request on one port, then measure latency, mode pulses and stray responses.
    task automatic applyStimulus(input int d, input int p, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input int expLat, input string tag);
        int waitCycles = 0;
        int lat = 0;
        int modeCycles = 0;
        int otherPulses = 0;
        @(negedge clk);
        reqValid[d][p] = 1'b1;
        reqWe[d][p]    = we;
        reqAddr[d][p]  = addr;
        reqWdata[d][p] = wdata;
        #1;
        while (!reqReady[d][p] && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, " readyWait"}, 32'(waitCycles), 32'd0);
        if (waitCycles >= 50) begin
            reqValid[d][p] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        reqValid[d][p] = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (memMode[d]) modeCycles++;
            if (rspValid[d][1-p]) otherPulses++;
            if (rspValid[d][p]) break;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " rdata"}, rspRdata[d][p], expData);
        checkOutput({tag, " modeCycles"}, 32'(modeCycles), we ? 32'd1 : 32'd0);
        checkOutput({tag, " otherRsp"}, 32'(otherPulses), 32'd0);
        if (lat < 40) begin
            @(negedge clk);
            checkOutput({tag, " pulseWidth"}, 32'(rspValid[d][p]), 32'd0);
            checkOutput({tag, " rdataHold"}, rspRdata[d][p], expData);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int both;
        int pulses;
        int w;
        int order[$];
        logic [31:0] odata[$];

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                reqValid[d][p] = 1'b0;
                reqWe[d][p]    = 1'b0;
                reqAddr[d][p]  = 32'h0;
                reqWdata[d][p] = 32'h0;
            end
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        memInit = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset rsp0Valid", 32'(rspValid[d][0]), 32'd0);
            checkOutput("reset rsp1Valid", 32'(rspValid[d][1]), 32'd0);
            checkOutput("reset rsp0Rdata", rspRdata[d][0], 32'h0);
            checkOutput("reset rsp1Rdata", rspRdata[d][1], 32'h0);
            checkOutput("reset memAddress", memAddress[d], 32'h0);
            checkOutput("reset memData", memData[d], 32'h0);
            checkOutput("reset memMode", 32'(memMode[d]), 32'd0);
        end
        rst = 1'b0;

        $display("[TB] single write and read-after-write, latency 1");
        applyStimulus(0, 0, 1'b1, 32'h40, 32'h1122_3344, 32'h1122_3344, 3, "wr p0");
        applyStimulus(0, 1, 1'b0, 32'h40, 32'h0, 32'h1122_3344, 3, "raw p1");

        $display("[TB] latency 3 instance");
        applyStimulus(1, 0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'hCAFE_F00D, 5, "lat3 wr");
        applyStimulus(1, 0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 5, "lat3 rd40");
        applyStimulus(1, 0, 1'b0, 32'h80, 32'h0, 32'hA000_0020, 5, "lat3 rd80");

        $display("[TB] async reset in the middle of WAIT");
        @(negedge clk);
        reqValid[1][1] = 1'b1;
        reqWe[1][1]    = 1'b1;
        reqAddr[1][1]  = 32'h8;
        reqWdata[1][1] = 32'h5555_AAAA;
        #1;
        checkOutput("rstMid ready", 32'(reqReady[1][1]), 32'd1);
        @(posedge clk);
        #1;
        reqValid[1][1] = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstMid rsp0Valid", 32'(rspValid[1][0]), 32'd0);
        checkOutput("rstMid rsp1Valid", 32'(rspValid[1][1]), 32'd0);
        checkOutput("rstMid memMode", 32'(memMode[1]), 32'd0);
        checkOutput("rstMid memAddress", memAddress[1], 32'h0);
        checkOutput("rstMid rsp0Rdata", rspRdata[1][0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rspValid[1][0] || rspValid[1][1]) pulses++;
        end
        checkOutput("rstMid noRsp", 32'(pulses), 32'd0);
        applyStimulus(1, 1, 1'b0, 32'h8, 32'h0, 32'h5555_AAAA, 5, "rstMid recover");

        $display("[TB] contention from reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reqValid[0][0] = 1'b1; reqWe[0][0] = 1'b0; reqAddr[0][0] = 32'h80;
        reqValid[0][1] = 1'b1; reqWe[0][1] = 1'b0; reqAddr[0][1] = 32'h40;
        n = 0;
        both = 0;
        while (order.size() < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (reqReady[0][0] && reqReady[0][1]) both++;
            if (rspValid[0][0]) begin order.push_back(0); odata.push_back(rspRdata[0][0]); end
            if (rspValid[0][1]) begin order.push_back(1); odata.push_back(rspRdata[0][1]); end
        end
        reqValid[0][0] = 1'b0;
        reqValid[0][1] = 1'b0;
        checkOutput("contend count", 32'(order.size()), 32'd3);
        checkOutput("contend bothReady", 32'(both), 32'd0);
        if (order.size() == 3) begin
            checkOutput("contend first", 32'(order[0]), 32'd0);
            checkOutput("contend second", 32'(order[1]), 32'd1);
            checkOutput("contend third", 32'(order[2]), 32'd0);
            checkOutput("contend data0", odata[0], 32'hA000_0020);
            checkOutput("contend data1", odata[1], 32'h1122_3344);
            checkOutput("contend data2", odata[2], 32'hA000_0020);
        end
        repeat (6) @(negedge clk);

        $display("[TB] back-to-back on port 1");
        logB2B = 1'b1;
        @(negedge clk);
        reqValid[0][1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reqWe[0][1]    = (i < 4);
            reqAddr[0][1]  = 32'(4 * (i % 4));
            reqWdata[0][1] = (i < 4) ? 32'(i + 1) : 32'h0;
            #1;
            w = 0;
            while (!reqReady[0][1] && w < 50) begin
                @(negedge clk);
                w++;
            end
            checkOutput("b2b handshake", 32'(w < 50), 32'd1);
            if (w >= 50) break;
            @(posedge clk);
            #1;
        end
        reqValid[0][1] = 1'b0;
        n = 0;
        while (b2bTime.size() < 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b count", 32'(b2bTime.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < b2bTime.size()) begin
                checkOutput("b2b data", b2bData[i], (i < 4) ? 32'(i + 1) : 32'(i - 3));
                if (i > 0) checkOutput("b2b spacing", 32'(b2bTime[i] - b2bTime[i-1]), 32'd4);
            end
        end
        logB2B = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
